mult32_seq: RTL and testbench

//   Multi-cycle unsigned 32x32->64 shift-and-add multiplier.

---
 rtl/mult32_seq_pkg.sv | 14 +
 rtl/mult32_seq_if.sv | 23 ++
 rtl/mult32_seq_adder32.sv | 13 +
 rtl/mult32_seq.sv | 105 ++++++++++
 tb/tb_mult32_seq.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/mult32_seq_pkg.sv
// Shared constants and FSM encoding for the sequential 32x32 multiplier.
// MUL_WIDTH / MUL_CNT_W are the defaults picked up by the interface and the top.
package mul_pkg;

  localparam int MUL_WIDTH = 32;
  localparam int MUL_CNT_W = 6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mult32_seq_if.sv
// Request/response bundle between the CPU controller (master) and the MUL unit (slave).
// start is only honoured while busy is low; result is valid while done is high.
interface mult32_seq_if;
  import mul_pkg::*;

  logic                     start;
  logic [MUL_WIDTH-1:0]     operand1;
  logic [MUL_WIDTH-1:0]     operand2;
  logic                     busy;
  logic                     done;
  logic [2*MUL_WIDTH-1:0]   result;

  modport master (
    output start, operand1, operand2,
    input  busy, done, result
  );

  modport slave (
    input  start, operand1, operand2,
    output busy, done, result
  );

endinterface

// File: rtl/mult32_seq_adder32.sv
// 32-bit ripple-style adder with carry in/out; combinational, no handshake.
// Shared step adder of the multiplier.
module adder32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {32'd0, cin};

endmodule

// File: rtl/mult32_seq.sv
// Unsigned 32x32->64 shift-and-add multiplier, one add/shift per clock; start-to-done 33 clocks.
// No queueing: start is dropped while busy, so the controller stalls on busy/done.
module mult32_seq #(
  parameter int WIDTH = mul_pkg::MUL_WIDTH,
  parameter int CNT_W = mul_pkg::MUL_CNT_W
) (
  input logic         clk,
  input logic         rst,
  mult32_seq_if.slave bus
);
  import mul_pkg::*;

  if (WIDTH != 32) begin : g_bad_width
    $error("mult32_seq: WIDTH must be 32 to match the adder32 datapath");
  end
  if ((1 << CNT_W) <= WIDTH) begin : g_bad_cnt
    $error("mult32_seq: CNT_W too narrow for WIDTH iterations");
  end

  state_t               state;
  state_t               state_nxt;
  logic                 accept;
  logic                 last_step;

  logic [WIDTH-1:0]     mcand;
  logic [WIDTH-1:0]     acc_hi;
  logic [WIDTH-1:0]     acc_lo;
  logic [CNT_W-1:0]     cnt;
  logic [2*WIDTH-1:0]   result_q;

  logic [WIDTH-1:0]     addend;
  logic [WIDTH-1:0]     sum;
  logic                 cout;
  logic [2*WIDTH-1:0]   shifted;

  // Multiplier bits are consumed from acc_lo[0] as the partial product shifts in from the top.
  assign addend = acc_lo[0] ? mcand : '0;

  adder32 u_adder (
    .a    (acc_hi),
    .b    (addend),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  // Carry-out becomes the new MSB, so the 65-bit shift never loses a bit.
  assign shifted   = {cout, sum, acc_lo[WIDTH-1:1]};
  assign last_step = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = S_CALC;
        end
      end
      S_CALC: begin
        if (last_step) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand    <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      cnt      <= '0;
      result_q <= '0;
    end else if (accept) begin
      mcand  <= bus.operand1;
      acc_hi <= '0;
      acc_lo <= bus.operand2;
      cnt    <= '0;
    end else if (state == S_CALC) begin
      acc_hi <= shifted[2*WIDTH-1:WIDTH];
      acc_lo <= shifted[WIDTH-1:0];
      cnt    <= cnt + CNT_W'(1);
      if (last_step) begin
        result_q <= shifted;
      end
    end
  end

  assign bus.busy   = (state != S_IDLE);
  assign bus.done   = (state == S_DONE);
  assign bus.result = result_q;

endmodule

// File: tb/tb_mult32_seq.sv
// Scoreboard bench for mult32_seq: stimulus pushes reference products, a monitor pops on done.
module tb_mult32_seq;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mult32_seq_if bus ();

  mult32_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          mon_en = 1'b0;
  bit          have_last = 1'b0;
  bit          prev_done = 1'b0;
  logic [63:0] last_exp = '0;
  logic [63:0] exp_q[$];
  int          acc_q[$];
  int          done_cyc_q[$];
  logic [63:0] mon_exp;
  int          mon_acc;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] wa;
    logic [63:0] wb;
    wa = {32'd0, a};
    wb = {32'd0, b};
    return wa * wb;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic flag(input string name, input int act, input int req);
    checks++;
    errors++;
    $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  // Monitor: every done pulse must match the oldest outstanding job.
  always @(negedge clk) begin
    if (!rst && mon_en) begin
      if (bus.done) begin
        check("done_one_cycle", {63'd0, prev_done}, 64'd0);
        check("busy_in_done", {63'd0, bus.busy}, 64'd1);
        if (exp_q.size() == 0) begin
          flag("spurious_done", 1, 0);
        end else begin
          mon_exp = exp_q.pop_front();
          mon_acc = acc_q.pop_front();
          check("product", bus.result, mon_exp);
          check("latency", 64'(cyc - mon_acc), 64'd33);
          last_exp = mon_exp;
          done_cyc_q.push_back(cyc);
        end
      end else if (!bus.busy && have_last) begin
        check("result_hold", bus.result, last_exp);
      end
    end
    prev_done = bus.done;
  end

  // Waits for IDLE, presents a job for one edge and records its expected product.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit hold);
    int w;
    w = 0;
    @(negedge clk);
    while (bus.busy && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (bus.busy) begin
      flag("issue_timeout_busy", 1, 0);
      return;
    end
    bus.operand1 = a;
    bus.operand2 = b;
    bus.start    = 1'b1;
    exp_q.push_back(ref_mul(a, b));
    acc_q.push_back(cyc);
    @(posedge clk);
    #1;
    if (!hold) bus.start = 1'b0;
    check("busy_after_start", {63'd0, bus.busy}, 64'd1);
    bus.operand1 = $urandom;
    bus.operand2 = $urandom;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (exp_q.size() != 0) begin
      flag("drain_timeout_pending", exp_q.size(), 0);
      exp_q.delete();
      acc_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic pulse_start(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.operand1 = a;
    bus.operand2 = b;
    bus.start    = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  function automatic logic [31:0] pick(input int sel);
    case (sel)
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.start    = 1'b0;
    bus.operand1 = '0;
    bus.operand2 = '0;
    rst          = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {63'd0, bus.busy}, 64'd0);
    check("reset_done", {63'd0, bus.done}, 64'd0);
    check("reset_result", bus.result, 64'd0);
    rst       = 1'b0;
    last_exp  = '0;
    have_last = 1'b1;
    mon_en    = 1'b1;

    issue(32'd3, 32'd5, 1'b0);
    drain();
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    drain();
    issue(32'd0, 32'h1234_5678, 1'b0);
    drain();
    issue(32'h8000_0000, 32'd2, 1'b0);
    drain();

    // Starts at clocks 5 and 33 after acceptance land in CALC and DONE and must be dropped.
    issue(32'd1000, 32'd7, 1'b0);
    repeat (4) @(posedge clk);
    pulse_start(32'hDEAD_BEEF, 32'h1234_5678);
    repeat (27) @(posedge clk);
    pulse_start(32'hCAFE_F00D, 32'h0BAD_F00D);
    check("ignored_start_idle", {63'd0, bus.busy}, 64'd0);
    drain();

    // Reset mid-calculation, with start asserted alongside rst.
    issue(32'h0001_2345, 32'h0006_7890, 1'b0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst          = 1'b1;
    bus.start    = 1'b1;
    bus.operand1 = 32'd9;
    bus.operand2 = 32'd9;
    exp_q.delete();
    acc_q.delete();
    @(posedge clk);
    #1;
    rst       = 1'b0;
    bus.start = 1'b0;
    last_exp  = '0;
    check("abort_busy", {63'd0, bus.busy}, 64'd0);
    check("abort_done", {63'd0, bus.done}, 64'd0);
    check("abort_result", bus.result, 64'd0);
    repeat (40) @(negedge clk);
    issue(32'd123, 32'd456, 1'b0);
    drain();

    // start held high across three jobs.
    done_cyc_q.delete();
    issue(32'd11, 32'd13, 1'b1);
    issue(32'hFFFF_0000, 32'h0000_FFFF, 1'b1);
    issue(32'h7654_3210, 32'h89AB_CDEF, 1'b1);
    bus.start = 1'b0;
    drain();
    if (done_cyc_q.size() != 3) begin
      flag("b2b_done_count", done_cyc_q.size(), 3);
    end else begin
      check("b2b_spacing_1", 64'(done_cyc_q[1] - done_cyc_q[0]), 64'd34);
      check("b2b_spacing_2", 64'(done_cyc_q[2] - done_cyc_q[1]), 64'd34);
    end

    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(pick($urandom_range(0, 9)), pick($urandom_range(0, 9)), 1'b0);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
